// File: rtl/host_line_xfer.sv
// host_line_xfer: single-cacheline host transfer sequencer.
// Translates a 32-bit CPU address into a 64-bit host virtual address through
// four MMIO-programmed segment bases, then runs one size-1 DMA read or write
// and returns read data plus completion status. Unprogrammed segments and
// wait-state timeouts complete with rsp_err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mmio_wr_*                segment base / control register writes
//   req_*                    host-memory request (valid/ready handshake)
//   rsp_*                    one-cycle completion pulse, error flag, read line
//   busy                     block not idle
//   dma_rd_* / dma_empty     DMA read channel (go, address, size, pop, data, done)
//   dma_wr_* / dma_full      DMA write channel (go, address, size, push, data, done)
module host_line_xfer #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned SIZE_WIDTH     = 43,
  parameter logic [15:0] SEG_MMIO_BASE  = 16'h0020,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mmio_wr_en,
  input  logic [15:0]           mmio_wr_addr,
  input  logic [63:0]           mmio_wr_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  output logic                  dma_rd_en,
  input  logic                  dma_empty,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic                  dma_rd_done,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_full,
  input  logic                  dma_wr_done
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CTRL_ADDR = SEG_MMIO_BASE + 16'd8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GO      = 3'd1,
    RD_WAIT = 3'd2,
    RD_DONE = 3'd3,
    WR_WAIT = 3'd4,
    WR_DONE = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q [4];
  logic [3:0]            seg_valid_q;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] xaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [1:0]            seg;
  logic [ADDR_WIDTH-1:0] xaddr;
  logic                  accept;
  logic                  seg_err;
  logic                  timeout;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  set_tmo;
  logic                  unused_bits;

  // Line offset within the segment; byte-in-line bits are dropped.
  assign unused_bits = ^req_addr[5:0];
  assign seg         = req_addr[31:30];
  assign xaddr       = base_q[seg] + ADDR_WIDTH'({req_addr[29:6], 6'b0});
  assign seg_err     = !seg_valid_q[seg];
  assign accept      = req_valid && (state_q == IDLE);
  assign timeout     = (cnt_q == CNT_LAST);

  // Ready is forced low while reset is held so nothing is accepted then.
  assign req_ready   = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign dma_rd_addr = xaddr_q;
  assign dma_wr_addr = xaddr_q;
  assign dma_rd_size = SIZE_WIDTH'(1);
  assign dma_wr_size = SIZE_WIDTH'(1);
  assign dma_wr_data = wdata_q;
  assign rsp_rdata   = rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and strobes; timeout wins over any strobe in the same cycle.
  always_comb begin
    state_d   = state_q;
    dma_rd_go = 1'b0;
    dma_wr_go = 1'b0;
    dma_rd_en = 1'b0;
    dma_wr_en = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_tmo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = seg_err ? RESP : GO;
      end
      GO: begin
        cnt_clr = 1'b1;
        if (we_q) begin
          dma_wr_go = 1'b1;
          state_d   = WR_WAIT;
        end else begin
          dma_rd_go = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_inc = 1'b1;
        if (timeout) begin
          set_tmo = 1'b1;
          state_d = RESP;
        end else if (!dma_empty) begin
          dma_rd_en = 1'b1;
          state_d   = RD_DONE;
        end
      end
      RD_DONE: begin
        cnt_inc = 1'b1;
        if (timeout) begin
          set_tmo = 1'b1;
          state_d = RESP;
        end else if (dma_rd_done) begin
          state_d = RESP;
        end
      end
      WR_WAIT: begin
        cnt_inc = 1'b1;
        if (timeout) begin
          set_tmo = 1'b1;
          state_d = RESP;
        end else if (!dma_full) begin
          dma_wr_en = 1'b1;
          state_d   = WR_DONE;
        end
      end
      WR_DONE: begin
        cnt_inc = 1'b1;
        if (timeout) begin
          set_tmo = 1'b1;
          state_d = RESP;
        end else if (dma_wr_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Segment registers, request latch, timeout counter and read-line capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) base_q[n] <= '0;
      seg_valid_q <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      xaddr_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (mmio_wr_en && (mmio_wr_addr == SEG_MMIO_BASE + 16'(2 * n))) begin
          base_q[n]      <= ADDR_WIDTH'(mmio_wr_data);
          seg_valid_q[n] <= 1'b1;
        end
      end
      if (mmio_wr_en && (mmio_wr_addr == CTRL_ADDR) && mmio_wr_data[0])
        seg_valid_q <= '0;

      // Error requests leave the DMA-facing address and data untouched.
      if (accept) begin
        we_q  <= req_we;
        err_q <= seg_err;
        if (!seg_err) begin
          xaddr_q <= xaddr;
          wdata_q <= req_wdata;
        end
      end
      if (set_tmo) err_q <= 1'b1;

      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_WIDTH'(1);

      if (dma_rd_en) rdata_q <= dma_rd_data;
    end
  end

endmodule

// File: tb/tb_host_line_xfer.sv
// Directed self-checking bench for host_line_xfer (TIMEOUT_CYCLES = 16).
module tb_host_line_xfer;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned SW = 43;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mmio_wr_en = 1'b0;
  logic [15:0]   mmio_wr_addr = '0;
  logic [63:0]   mmio_wr_data = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [SW-1:0] dma_rd_size, dma_wr_size;
  logic          dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic          dma_empty = 1'b1;
  logic [DW-1:0] dma_rd_data = '0;
  logic          dma_rd_done = 1'b0;
  logic [DW-1:0] dma_wr_data;
  logic          dma_full = 1'b0;
  logic          dma_wr_done = 1'b0;

  always #5 clk = ~clk;

  host_line_xfer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
    .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go), .dma_rd_en(dma_rd_en),
    .dma_empty(dma_empty), .dma_rd_data(dma_rd_data), .dma_rd_done(dma_rd_done),
    .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_full(dma_full),
    .dma_wr_done(dma_wr_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event monitor: cycle stamps and pulse counts sampled at each active edge.
  int   cyc = 0, acc_cyc = 0, rd_go_cyc = 0, rd_en_cyc = 0, wr_en_cyc = 0, rsp_cyc = 0;
  int   n_rd_go = 0, n_wr_go = 0, n_rd_en = 0, n_wr_en = 0, n_rsp = 0, n_multi = 0;
  logic last_err = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc <= cyc;
    if (dma_rd_go) begin n_rd_go <= n_rd_go + 1; rd_go_cyc <= cyc; end
    if (dma_wr_go) n_wr_go <= n_wr_go + 1;
    if (dma_rd_en) begin n_rd_en <= n_rd_en + 1; rd_en_cyc <= cyc; end
    if (dma_wr_en) begin n_wr_en <= n_wr_en + 1; wr_en_cyc <= cyc; end
    if (rsp_valid) begin n_rsp <= n_rsp + 1; rsp_cyc <= cyc; last_err <= rsp_err; end
    if ((32'(dma_rd_go) + 32'(dma_wr_go) + 32'(dma_rd_en) + 32'(dma_wr_en)) > 32'd1)
      n_multi <= n_multi + 1;
  end

  function automatic int strobes();
    return n_rd_go + n_wr_go + n_rd_en + n_wr_en;
  endfunction

  task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    mmio_wr_en = 1'b1; mmio_wr_addr = a; mmio_wr_data = d;
    @(negedge clk);
    mmio_wr_en = 1'b0;
  endtask

  // Returns at the negedge of the cycle after acceptance (GO or RESP).
  task automatic issue(input logic we, input logic [31:0] a, input logic [DW-1:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (n_rsp != start) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check(tag, DW'(seen), DW'(1));
  endtask

  task automatic expect_err(input logic [31:0] a, input string tag, input logic [AW-1:0] exp_addr);
    int s_rsp, s_str;
    s_rsp = n_rsp;
    s_str = strobes();
    issue(1'b0, a, '0);
    wait_rsp(s_rsp, {tag, "_rsp"});
    check({tag, "_err"}, DW'(last_err), DW'(1));
    check({tag, "_lat"}, DW'(rsp_cyc), DW'(acc_cyc + 1));
    check({tag, "_nostrobe"}, DW'(strobes() - s_str), DW'(0));
    check({tag, "_addr"}, DW'(dma_rd_addr), DW'(exp_addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] line1, line3, line4, line5, wd2;
    int s_rsp, s_rdgo, s_rden, s_wrgo, s_wren, s_rdall;

    line1 = {16{32'hA5A5_0001}};
    wd2   = {16{32'h5A5A_0002}};
    line3 = {16{32'h3333_0003}};
    line4 = {16{32'hC4C4_0004}};
    line5 = {16{32'h0505_0005}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", DW'(req_ready), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_rsp", DW'({rsp_valid, rsp_err}), DW'(0));
    check("rst_rdata", rsp_rdata, DW'(0));
    check("rst_addr", DW'(dma_rd_addr), DW'(0));
    check("rst_strobes", DW'({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), DW'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", DW'(req_ready), DW'(1));
    check("size_rd", DW'(dma_rd_size), DW'(1));
    check("size_wr", DW'(dma_wr_size), DW'(1));

    // t1: read through segment 1 at minimum latency.
    mmio_write(16'h0022, 64'h0000_7F00_0000_0000);
    s_rsp = n_rsp; s_rden = n_rd_en; s_wrgo = n_wr_go; s_wren = n_wr_en;
    issue(1'b0, 32'h4000_0080, '0);
    check("t1_addr", DW'(dma_rd_addr), DW'(64'h0000_7F00_0000_0080));
    check("t1_busy", DW'(busy), DW'(1));
    dma_rd_data = line1; dma_empty = 1'b0; dma_rd_done = 1'b1;
    wait_rsp(s_rsp, "t1_rsp");
    check("t1_go_cyc", DW'(rd_go_cyc), DW'(acc_cyc + 1));
    check("t1_en_cyc", DW'(rd_en_cyc), DW'(acc_cyc + 2));
    check("t1_rsp_cyc", DW'(rsp_cyc), DW'(acc_cyc + 4));
    check("t1_err", DW'(last_err), DW'(0));
    check("t1_rdata", rsp_rdata, line1);
    check("t1_en_count", DW'(n_rd_en - s_rden), DW'(1));
    check("t1_no_wr", DW'((n_wr_go - s_wrgo) + (n_wr_en - s_wren)), DW'(0));
    dma_empty = 1'b1; dma_rd_done = 1'b0; dma_rd_data = '0;

    // t2: write with the channel full for several cycles.
    dma_full = 1'b1;
    s_rsp = n_rsp; s_wrgo = n_wr_go; s_wren = n_wr_en; s_rdall = n_rd_go + n_rd_en;
    issue(1'b1, 32'h4000_1000, wd2);
    check("t2_addr", DW'(dma_wr_addr), DW'(64'h0000_7F00_0000_1000));
    repeat (5) @(negedge clk);
    check("t2_en_while_full", DW'(n_wr_en - s_wren), DW'(0));
    check("t2_wdata", dma_wr_data, wd2);
    dma_full = 1'b0; dma_wr_done = 1'b1;
    wait_rsp(s_rsp, "t2_rsp");
    repeat (3) @(negedge clk);
    check("t2_en_count", DW'(n_wr_en - s_wren), DW'(1));
    check("t2_en_cyc", DW'(wr_en_cyc), DW'(acc_cyc + 6));
    check("t2_go_count", DW'(n_wr_go - s_wrgo), DW'(1));
    check("t2_rsp_count", DW'(n_rsp - s_rsp), DW'(1));
    check("t2_err", DW'(last_err), DW'(0));
    check("t2_no_rd", DW'((n_rd_go + n_rd_en) - s_rdall), DW'(0));
    dma_wr_done = 1'b0;

    // t3: unprogrammed segment 2.
    expect_err(32'h8000_0040, "t3", 64'h0000_7F00_0000_1000);
    check("t3_rdata_held", rsp_rdata, line1);

    // t3b: MMIO write to base 0 in the acceptance cycle does not apply.
    s_rsp = n_rsp;
    @(negedge clk);
    mmio_wr_en = 1'b1; mmio_wr_addr = 16'h0020; mmio_wr_data = 64'h5000;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_00C0;
    @(negedge clk);
    mmio_wr_en = 1'b0; req_valid = 1'b0;
    wait_rsp(s_rsp, "t3b_rsp");
    check("t3b_err", DW'(last_err), DW'(1));
    s_rsp = n_rsp;
    issue(1'b0, 32'h0000_00C0, '0);
    check("t3b_addr", DW'(dma_rd_addr), DW'(64'h50C0));
    dma_rd_data = line3; dma_empty = 1'b0; dma_rd_done = 1'b1;
    wait_rsp(s_rsp, "t3b_rsp2");
    check("t3b_err2", DW'(last_err), DW'(0));
    check("t3b_rdata", rsp_rdata, line3);
    dma_empty = 1'b1; dma_rd_done = 1'b0;

    // t4: address wraps modulo 2^64; MMIO while busy leaves xaddr alone.
    mmio_write(16'h0026, 64'hFFFF_FFFF_FFFF_FFC0);
    s_rsp = n_rsp;
    issue(1'b0, 32'hC000_0040, '0);
    check("t4_wrap_addr", DW'(dma_rd_addr), DW'(0));
    mmio_write(16'h0026, 64'h1234_0000);
    check("t4_busy", DW'(busy), DW'(1));
    check("t4_addr_kept", DW'(dma_rd_addr), DW'(0));
    dma_rd_data = line4; dma_empty = 1'b0; dma_rd_done = 1'b1;
    wait_rsp(s_rsp, "t4_rsp");
    check("t4_err", DW'(last_err), DW'(0));
    check("t4_rdata", rsp_rdata, line4);
    dma_empty = 1'b1; dma_rd_done = 1'b0;

    // t5: timeout with dma_empty held high (base 3 updated during t4).
    s_rsp = n_rsp; s_rdgo = n_rd_go; s_rden = n_rd_en;
    issue(1'b0, 32'hC000_0040, '0);
    check("t5_addr", DW'(dma_rd_addr), DW'(64'h1234_0040));
    wait_rsp(s_rsp, "t5_rsp");
    check("t5_rsp_cyc", DW'(rsp_cyc), DW'(acc_cyc + 18));
    check("t5_err", DW'(last_err), DW'(1));
    check("t5_no_en", DW'(n_rd_en - s_rden), DW'(0));
    check("t5_go", DW'(n_rd_go - s_rdgo), DW'(1));
    check("t5_ready_back", DW'(req_ready), DW'(1));
    check("t5_idle", DW'(busy), DW'(0));

    // t6: reset in RD_DONE drops the transfer silently.
    s_rsp = n_rsp; s_rden = n_rd_en;
    issue(1'b0, 32'h4000_0000, '0);
    dma_rd_data = line5; dma_empty = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dma_empty = 1'b1;
    check("t6_in_done", DW'(busy), DW'(1));
    check("t6_en", DW'(n_rd_en - s_rden), DW'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", DW'(req_ready), DW'(0));
    check("t6_rst_idle", DW'({busy, rsp_valid}), DW'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_ready", DW'(req_ready), DW'(1));
    check("t6_rdata_rst", rsp_rdata, DW'(0));
    dma_rd_done = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_rsp", DW'(n_rsp - s_rsp), DW'(0));
    dma_rd_done = 1'b0;
    expect_err(32'h4000_0000, "t6_post", 64'h0);

    // t7: control register clears every segment valid bit.
    mmio_write(16'h0022, 64'h100);
    mmio_write(16'h0028, 64'h1);
    expect_err(32'h4000_0000, "t7", 64'h0);

    check("one_strobe_per_cycle", DW'(n_multi), DW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
